// File: rtl/lz77_pkg.sv
// Shared LZ77 definitions: width helpers, encoder FSM states and the token
// layout exchanged with the decoder.
package lz77_pkg;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int unsigned off_w(input int unsigned search_len);
    return clog2_min1(search_len);
  endfunction

  function automatic int unsigned len_w(input int unsigned look_len);
    return clog2_min1(look_len);
  endfunction

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SEARCH = 2'd1,
    EMIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int unsigned TOK_CHAR_W = 8;
  localparam int unsigned TOK_OFF_W  = off_w(9);
  localparam int unsigned TOK_LEN_W  = len_w(8);

  typedef struct packed {
    logic [TOK_OFF_W-1:0]  offset;
    logic [TOK_LEN_W-1:0]  match_len;
    logic [TOK_CHAR_W-1:0] char_nxt;
  } tok_t;

endpackage

// File: rtl/lz77_match_scan.sv
// Longest-match search: walks candidates newest-first, one char compare per
// cycle, keeping the longest match (earliest candidate wins ties).
module lz77_match_scan
  import lz77_pkg::*;
#(
  parameter  int unsigned CHAR_W     = 8,
  parameter  int unsigned SEARCH_LEN = 9,
  parameter  int unsigned LOOK_LEN   = 8,
  parameter  int unsigned BUF_DEPTH  = 32,
  localparam int unsigned OFF_W      = off_w(SEARCH_LEN),
  localparam int unsigned LEN_W      = len_w(LOOK_LEN),
  localparam int unsigned PW         = $clog2(BUF_DEPTH + 1),
  localparam int unsigned AW         = clog2_min1(BUF_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [PW-1:0]     i_p,
  input  logic [LEN_W-1:0]  i_max_len,
  output logic [AW-1:0]     o_addr_cand,
  output logic [AW-1:0]     o_addr_look,
  input  logic [CHAR_W-1:0] i_data_cand,
  input  logic [CHAR_W-1:0] i_data_look,
  output logic [OFF_W-1:0]  o_best_off,
  output logic [LEN_W-1:0]  o_best_len,
  output logic              o_done
);

  logic              r_active;
  logic              r_done;
  logic [PW-1:0]     r_dist;
  logic [LEN_W-1:0]  r_k;
  logic [OFF_W-1:0]  r_best_off;
  logic [LEN_W-1:0]  r_best_len;

  logic [PW-1:0]     w_wsize;
  logic              w_eq;
  logic [LEN_W:0]    w_k_inc;
  logic [LEN_W:0]    w_cand_len;
  logic [LEN_W:0]    w_max_ext;
  logic              w_cand_end;
  logic              w_scan_end;

  // Window depth clamps at the start of the buffer.
  assign w_wsize    = (32'(i_p) > SEARCH_LEN) ? PW'(SEARCH_LEN) : i_p;

  assign o_addr_cand = AW'(i_p - r_dist + PW'(r_k));
  assign o_addr_look = AW'(i_p + PW'(r_k));

  assign w_eq       = (i_data_cand == i_data_look);
  assign w_k_inc    = (LEN_W+1)'(r_k) + (LEN_W+1)'(1);
  assign w_max_ext  = (LEN_W+1)'(i_max_len);
  assign w_cand_len = w_eq ? w_k_inc : (LEN_W+1)'(r_k);
  assign w_cand_end = !w_eq || (w_k_inc == w_max_ext);
  assign w_scan_end = (w_cand_len == w_max_ext) || (r_dist == w_wsize);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_active   <= 1'b0;
      r_done     <= 1'b0;
      r_dist     <= '0;
      r_k        <= '0;
      r_best_off <= '0;
      r_best_len <= '0;
    end else if (i_start) begin
      r_dist     <= PW'(1);
      r_k        <= '0;
      r_best_off <= '0;
      r_best_len <= '0;
      r_active   <= (i_p != '0) && (i_max_len != '0);
      r_done     <= !((i_p != '0) && (i_max_len != '0));
    end else if (r_active) begin
      if (w_cand_end) begin
        if (w_cand_len > (LEN_W+1)'(r_best_len)) begin
          r_best_len <= LEN_W'(w_cand_len);
          r_best_off <= OFF_W'(r_dist - PW'(1));
        end
        if (w_scan_end) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end else begin
          r_dist <= r_dist + PW'(1);
          r_k    <= '0;
        end
      end else begin
        r_k <= LEN_W'(w_k_inc);
      end
    end
  end

  assign o_best_off = r_best_off;
  assign o_best_len = r_best_len;
  assign o_done     = r_done;

endmodule

// File: rtl/lz77_enc_param.sv
// Parametrised LZ77 encoder: buffers a string, then emits backpressured
// (offset, match_len, char_nxt) tokens over a sliding search window.
module lz77_enc_param
  import lz77_pkg::*;
#(
  parameter  int unsigned CHAR_W     = 8,
  parameter  int unsigned SEARCH_LEN = 9,
  parameter  int unsigned LOOK_LEN   = 8,
  parameter  int unsigned BUF_DEPTH  = 32,
  localparam int unsigned OFF_W      = off_w(SEARCH_LEN),
  localparam int unsigned LEN_W      = len_w(LOOK_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              out_ready,
  output logic              busy,
  output logic              valid,
  output logic              encode,
  output logic [OFF_W-1:0]  offset,
  output logic [LEN_W-1:0]  match_len,
  output logic [CHAR_W-1:0] char_nxt,
  output logic              done
);

  localparam int unsigned PW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned AW = clog2_min1(BUF_DEPTH);

  typedef struct packed {
    logic [OFF_W-1:0]  offset;
    logic [LEN_W-1:0]  match_len;
    logic [CHAR_W-1:0] char_nxt;
  } enc_tok_t;

  state_t            r_state, w_state_nxt;
  logic [CHAR_W-1:0] r_buf [BUF_DEPTH];
  logic [PW-1:0]     r_len, w_len_nxt;
  logic [PW-1:0]     r_p, w_p_nxt;
  logic              r_scan_started, w_scan_started_nxt;
  enc_tok_t          r_tok, w_tok_nxt;
  logic              r_busy, r_valid, r_done;

  logic              w_len_full;
  logic              w_store;
  logic              w_scan_start;
  logic              w_scan_done;
  logic [PW-1:0]     w_rem;
  logic [PW-1:0]     w_p_adv;
  logic [LEN_W-1:0]  w_max_len;
  logic [LEN_W-1:0]  w_best_len;
  logic [OFF_W-1:0]  w_best_off;
  logic [AW-1:0]     w_addr_cand, w_addr_look;

  assign w_len_full   = (32'(r_len) >= BUF_DEPTH);
  assign w_store      = (r_state == LOAD) && code_valid && !w_len_full;
  assign w_rem        = r_len - r_p - PW'(1);
  // Match length is capped so that a literal always follows the match.
  assign w_max_len    = (32'(w_rem) < LOOK_LEN - 1) ? LEN_W'(w_rem) : LEN_W'(LOOK_LEN - 1);
  assign w_p_adv      = r_p + PW'(r_tok.match_len) + PW'(1);
  assign w_scan_start = (r_state == SEARCH) && !r_scan_started;

  lz77_match_scan #(
    .CHAR_W     (CHAR_W),
    .SEARCH_LEN (SEARCH_LEN),
    .LOOK_LEN   (LOOK_LEN),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_scan (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_scan_start),
    .i_p         (r_p),
    .i_max_len   (w_max_len),
    .o_addr_cand (w_addr_cand),
    .o_addr_look (w_addr_look),
    .i_data_cand (r_buf[w_addr_cand]),
    .i_data_look (r_buf[w_addr_look]),
    .o_best_off  (w_best_off),
    .o_best_len  (w_best_len),
    .o_done      (w_scan_done)
  );

  always_comb begin
    w_state_nxt        = r_state;
    w_len_nxt          = r_len;
    w_p_nxt            = r_p;
    w_scan_started_nxt = r_scan_started;
    w_tok_nxt          = r_tok;
    case (r_state)
      LOAD: begin
        if (w_store) w_len_nxt = r_len + PW'(1);
        if ((w_store && (32'(r_len) == BUF_DEPTH - 1)) || w_len_full ||
            (!code_valid && (r_len != '0))) begin
          w_state_nxt        = SEARCH;
          w_p_nxt            = '0;
          w_scan_started_nxt = 1'b0;
        end
      end
      SEARCH: begin
        if (!r_scan_started) begin
          w_scan_started_nxt = 1'b1;
        end else if (w_scan_done) begin
          w_tok_nxt.offset    = w_best_off;
          w_tok_nxt.match_len = w_best_len;
          w_tok_nxt.char_nxt  = r_buf[AW'(r_p + PW'(w_best_len))];
          w_state_nxt         = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          w_p_nxt            = w_p_adv;
          w_scan_started_nxt = 1'b0;
          w_state_nxt        = (w_p_adv == r_len) ? FINISH : SEARCH;
        end
      end
      FINISH: begin
        w_len_nxt   = '0;
        w_p_nxt     = '0;
        w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= LOAD;
      r_len          <= '0;
      r_p            <= '0;
      r_scan_started <= 1'b0;
      r_tok          <= '0;
      r_busy         <= 1'b0;
      r_valid        <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_len          <= w_len_nxt;
      r_p            <= w_p_nxt;
      r_scan_started <= w_scan_started_nxt;
      r_tok          <= w_tok_nxt;
      r_busy         <= (w_state_nxt == SEARCH) || (w_state_nxt == EMIT);
      r_valid        <= (w_state_nxt == EMIT);
      r_done         <= (w_state_nxt == FINISH);
    end
  end

  // String storage; contents are meaningless once len is cleared.
  always_ff @(posedge clk) begin
    if (reset && w_store) r_buf[AW'(r_len)] <= chardata;
  end

  assign busy      = r_busy;
  assign valid     = r_valid;
  assign encode    = r_valid;
  assign offset    = r_tok.offset;
  assign match_len = r_tok.match_len;
  assign char_nxt  = r_tok.char_nxt;
  assign done      = r_done;

endmodule

// File: tb/tb_lz77_enc_param.sv
// Scoreboard bench for lz77_enc_param: a plain LZ77 reference model fills the
// expected-token queue, a negedge monitor checks every accepted token.
module tb_lz77_enc_param;

  typedef logic [7:0] str_t[$];
  typedef struct packed {
    logic [3:0] off;
    logic [2:0] len;
    logic [7:0] ch;
  } tok_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [7:0] chardata;
  logic       out_ready;
  logic       busy, valid, encode, done;
  logic [3:0] offset;
  logic [2:0] match_len;
  logic [7:0] char_nxt;

  int vectors     = 0;
  int miscompares = 0;
  int accepted    = 0;
  int rdy_mode    = 0;
  tok_t exp_q[$];

  lz77_enc_param dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .chardata   (chardata),
    .out_ready  (out_ready),
    .busy       (busy),
    .valid      (valid),
    .encode     (encode),
    .offset     (offset),
    .match_len  (match_len),
    .char_nxt   (char_nxt),
    .done       (done)
  );

  always #5 clk = ~clk;

  tok_t cur;
  assign cur = '{off: offset, len: match_len, ch: char_nxt};

  // Greedy LZ77 reference: search 9 back, match at most 7, literal follows.
  function automatic void push_model(input str_t s);
    int n;
    int p;
    tok_t t;
    n = s.size();
    p = 0;
    while (p < n) begin
      int lmax;
      int best;
      int boff;
      lmax = (n - 1 - p < 7) ? (n - 1 - p) : 7;
      best = 0;
      boff = 0;
      for (int d = 1; d <= p && d <= 9; d++) begin
        int m;
        m = 0;
        while (m < lmax && s[p-d+m] == s[p+m]) m++;
        if (m > best) begin
          best = m;
          boff = d - 1;
        end
      end
      t.off = 4'(boff);
      t.len = 3'(best);
      t.ch  = s[p+best];
      exp_q.push_back(t);
      p += best + 1;
    end
  endfunction

  function automatic str_t to_q(input string t);
    str_t q;
    for (int i = 0; i < t.len(); i++) q.push_back(t[i]);
    return q;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input str_t s);
    foreach (s[i]) begin
      code_valid = 1'b1;
      chardata   = s[i];
      @(posedge clk); #1;
    end
    code_valid = 1'b0;
    chardata   = 8'h00;
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: done not seen, %0d tokens still expected", name, exp_q.size());
      exp_q.delete();
    end else begin
      check({name, "_busy_at_done"}, 32'(busy), 32'd0);
      check({name, "_leftover_tokens"}, 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check({name, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  task automatic run(input string name, input str_t s);
    push_model(s);
    load(s);
    wait_done(name);
  endtask

  task automatic wait_cond_valid(input string name);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: valid never rose, got 0 expected 1", name);
    end
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on every acceptance, and checks a stalled token holds.
  initial begin
    bit   stalled;
    tok_t held;
    tok_t e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          vectors++;
          if (!valid || cur !== held) begin
            miscompares++;
            $display("FAIL hold: got valid=%0d tok=%0h expected valid=1 tok=%0h", valid, cur, held);
          end
        end
        if (valid && out_ready) begin
          vectors++;
          accepted++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL token: got unexpected (%0d,%0d,%0h) expected none", offset, match_len, char_nxt);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e || encode !== 1'b1) begin
              miscompares++;
              $display("FAIL token: got (%0d,%0d,%0h) enc=%0d expected (%0d,%0d,%0h) enc=1",
                       offset, match_len, char_nxt, encode, e.off, e.len, e.ch);
            end
          end
        end
        stalled = valid && !out_ready;
        held    = cur;
      end
    end
  end

  initial begin
    str_t s;
    reset      = 1'b0;
    code_valid = 1'b0;
    chardata   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({valid, encode, busy, done, offset, match_len, char_nxt}), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    rdy_mode = 0;
    run("aaaa", to_q("aaaa"));
    run("abcabcd", to_q("abcabcd"));
    run("a10ba", to_q("abbbbbbbbbba"));

    // Backpressure on the first token.
    rdy_mode = 2;
    s = to_q("abcabcd");
    push_model(s);
    load(s);
    wait_cond_valid("stall_valid");
    repeat (20) @(posedge clk);
    rdy_mode = 0;
    wait_done("stall");

    // Overflow: 40 chars offered, only the first 32 are kept.
    rdy_mode = 1;
    s.delete();
    for (int i = 0; i < 40; i++) s.push_back(8'h61 + 8'($urandom_range(0, 2)));
    begin
      str_t s32;
      for (int i = 0; i < 32; i++) s32.push_back(s[i]);
      push_model(s32);
    end
    foreach (s[i]) begin
      code_valid = 1'b1;
      chardata   = s[i];
      @(posedge clk); #1;
      if (i == 30) check("ovf_busy_before_full", 32'(busy), 32'd0);
      if (i == 31) check("ovf_busy_after_full", 32'(busy), 32'd1);
    end
    code_valid = 1'b0;
    wait_done("overflow");

    // Reset during the second token's EMIT.
    rdy_mode = 0;
    accepted = 0;
    s = to_q("abcabcd");
    push_model(s);
    load(s);
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        if (accepted >= 1) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        vectors++;
        miscompares++;
        $display("FAIL rst_first_token: got 0 accepted expected 1");
      end
    end
    rdy_mode = 2;
    wait_cond_valid("rst_second_valid");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_emit_outputs", 32'({valid, encode, busy, done, offset, match_len, char_nxt}), 32'd0);
    exp_q.delete();
    reset    = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    run("aaaa_after_rst", to_q("aaaa"));

    // Random strings with random backpressure.
    rdy_mode = 1;
    for (int r = 0; r < 10; r++) begin
      int n;
      int alpha;
      n     = $urandom_range(1, 32);
      alpha = $urandom_range(0, 3);
      s.delete();
      for (int i = 0; i < n; i++) s.push_back(8'h61 + 8'($urandom_range(0, alpha)));
      run("random", s);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
